// File: rtl/branch_target_predictor_pkg.sv
// Shared types and helpers for the branch target predictor.
// The direction counter lives in its own sub-module, so the entry struct omits it.
package branch_target_predictor_pkg;

    localparam logic [31:0] PC_STEP = 32'd4;
    localparam int unsigned TAG_MAX = 30;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [31:0]        target;
    } bp_entry_t;

    function automatic logic [31:0] sat_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        return (v >= sat_max(w)) ? sat_max(w) : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// IF-stage lookup and EX-stage training bus of the branch target predictor.
// Statistics signals exist only when BP_STATS_EN is defined.
interface branch_target_predictor_if;

    logic        stall;
    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic [31:0] predict_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output stall, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  predict_taken, predict_pc, stat_branches, stat_mispredicts
    );
    modport slave (
        input  stall, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        output predict_taken, predict_pc, stat_branches, stat_mispredicts
    );
`else
    modport master (
        output stall, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  predict_taken, predict_pc
    );
    modport slave (
        input  stall, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        output predict_taken, predict_pc
    );
`endif

endinterface

// File: rtl/branch_target_predictor_sat_counter.sv
// Saturating up/down direction counter with load; resets to weakly-not-taken,
// load writes weakly-taken.
module branch_target_predictor_sat_counter
    import branch_target_predictor_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] RST_VAL  = W'((32'd1 << (W - 1)) - 32'd1);
    localparam logic [W-1:0] LOAD_VAL = W'(32'd1 << (W - 1));

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (inc_i) begin
            cnt_d = W'(sat_inc(32'(cnt_q), W));
        end else if (dec_i) begin
            cnt_d = W'(sat_dec(32'(cnt_q)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Define BP_STATS_EN to add saturating resolved-branch / misprediction counters.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_target_predictor_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("ENTRIES must be a power of two and at least 2");
    end
    if (IDX_W + TAG_W + 2 > 32) begin : g_bad_tag
        $error("IDX_W + TAG_W + 2 must not exceed 32");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
        $error("CNT_W must be between 1 and 32");
    end

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_MAX-1:0] tag_of(input logic [31:0] pc);
        return TAG_MAX'(pc[IDX_W+TAG_W+1:IDX_W+2]);
    endfunction

    bp_entry_t          tbl_q [ENTRIES];
    bp_entry_t          tbl_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_w [ENTRIES];

    logic [IDX_W-1:0]   lk_idx, upd_idx;
    logic [TAG_MAX-1:0] lk_tag, upd_tag;
    bp_entry_t          lk_entry, upd_entry;
    logic               lk_hit, upd_hit, upd_en;

    assign lk_idx   = idx_of(bus.lookup_pc);
    assign lk_tag   = tag_of(bus.lookup_pc);
    assign lk_entry = tbl_q[lk_idx];
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign bus.predict_taken = lk_hit && cnt_w[lk_idx][CNT_W-1];
    assign bus.predict_pc    = bus.predict_taken ? lk_entry.target : bus.lookup_pc + PC_STEP;

    assign upd_idx   = idx_of(bus.upd_pc);
    assign upd_tag   = tag_of(bus.upd_pc);
    assign upd_entry = tbl_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);
    assign upd_en    = bus.upd_valid && !bus.stall;

    // Taken outcomes always rewrite the whole entry: refresh on hit, allocate on miss.
    always_comb begin
        tbl_d = tbl_q;
        if (upd_en && bus.upd_taken) begin
            tbl_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, target: bus.upd_target};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

    for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_cnt
        logic sel;
        assign sel = upd_en && (upd_idx == IDX_W'(g));

        branch_target_predictor_sat_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc_i  (sel && upd_hit && bus.upd_taken),
            .dec_i  (sel && upd_hit && !bus.upd_taken),
            .load_i (sel && !upd_hit && bus.upd_taken),
            .cnt_o  (cnt_w[g])
        );
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (upd_en) begin
            if (stat_br_q != 32'hFFFF_FFFF) begin
                stat_br_d = stat_br_q + 32'd1;
            end
            if (bus.upd_mispredict && stat_mp_q != 32'hFFFF_FFFF) begin
                stat_mp_d = stat_mp_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign bus.stat_branches    = stat_br_q;
    assign bus.stat_mispredicts = stat_mp_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lookup_pc, bus.upd_pc};
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lookup_pc, bus.upd_pc, bus.upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor against an array-based reference model.
// Statistics checks are active when BP_STATS_EN is defined.
module tb_branch_target_predictor;

    localparam int ENTRIES = 16;
    localparam int TAG_W   = 8;
    localparam int CNT_W   = 2;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int WEAK_T  = 1 << (CNT_W - 1);
    localparam int WEAK_NT = WEAK_T - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_target_predictor_if bus();

    branch_target_predictor #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    longint      m_br;
    longint      m_mp;

    function automatic int unsigned f_idx(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned f_tag(input logic [31:0] pc);
        return ((pc / 4) / ENTRIES) % (1 << TAG_W);
    endfunction

    function automatic bit f_hit(input logic [31:0] pc);
        return m_valid[f_idx(pc)] && (m_tag[f_idx(pc)] == f_tag(pc));
    endfunction

    function automatic bit f_taken(input logic [31:0] pc);
        return f_hit(pc) && (m_cnt[f_idx(pc)] >= WEAK_T);
    endfunction

    function automatic logic [31:0] f_pc(input logic [31:0] pc);
        return f_taken(pc) ? m_target[f_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic logic [31:0] rand_pc();
        int unsigned tg;
        case ($urandom_range(0, 3))
            0:       tg = 4;
            1:       tg = 5;
            2:       tg = 6;
            default: tg = 8'hAB;
        endcase
        return ($urandom() & 32'hFFFF_C000) | (tg << 6) | ($urandom_range(0, ENTRIES - 1) << 2)
               | $urandom_range(0, 3);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = WEAK_NT;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic m_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                            input bit mis);
        int unsigned i;
        i = f_idx(pc);
        if (f_hit(pc)) begin
            if (tk) begin
                m_cnt[i]    = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
                m_target[i] = tgt;
            end else begin
                m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
            end
        end else if (tk) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = f_tag(pc);
            m_target[i] = tgt;
            m_cnt[i]    = WEAK_T;
        end
        m_br = m_br + 1;
        if (mis) m_mp = m_mp + 1;
    endtask

    task automatic idle_inputs();
        bus.stall          = 1'b0;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = '0;
        bus.upd_taken      = 1'b0;
        bus.upd_target     = '0;
        bus.upd_mispredict = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                             input bit mis, input bit st);
        @(negedge clk);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_taken      = tk;
        bus.upd_target     = tgt;
        bus.upd_mispredict = mis;
        bus.stall          = st;
        @(posedge clk);
        #1;
        idle_inputs();
        if (!st) m_update(pc, tk, tgt, mis);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        m_reset();
        bus.lookup_pc = 32'h1C09_0048;
        #1;
        n_vec++;
        if (bus.predict_taken !== 1'b0 || bus.predict_pc !== 32'h1C09_004C) begin
            n_err++;
            $display("FAIL reset_lookup: got taken=%b pc=%h, want taken=0 pc=1c09004c",
                     bus.predict_taken, bus.predict_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.lookup_pc = 32'hFFFF_FFFC;
        #1;
        n_vec++;
        if (bus.predict_taken !== 1'b0 || bus.predict_pc !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL pc_wrap: got taken=%b pc=%h, want taken=0 pc=00000000",
                     bus.predict_taken, bus.predict_pc);
        end
`ifdef BP_STATS_EN
        n_vec++;
        if (bus.stat_branches !== 32'd0 || bus.stat_mispredicts !== 32'd0) begin
            n_err++;
            $display("FAIL reset_stats: got br=%0d mp=%0d, want 0 0",
                     bus.stat_branches, bus.stat_mispredicts);
        end
`endif
    endtask

    typedef struct {
        bit          tk;
        logic [31:0] tgt;
        bit          et;
        logic [31:0] ep;
    } step_t;

    task automatic test_train();
        step_t steps[9];
        steps = '{
            '{1'b1, 32'h200, 1'b1, 32'h200},
            '{1'b0, 32'h0,   1'b0, 32'h104},
            '{1'b0, 32'h0,   1'b0, 32'h104},
            '{1'b0, 32'h0,   1'b0, 32'h104},
            '{1'b1, 32'h240, 1'b0, 32'h104},
            '{1'b1, 32'h280, 1'b1, 32'h280},
            '{1'b1, 32'h2C0, 1'b1, 32'h2C0},
            '{1'b1, 32'h2C0, 1'b1, 32'h2C0},
            '{1'b0, 32'h0,   1'b1, 32'h2C0}
        };
        foreach (steps[s]) begin
            do_update(32'h100, steps[s].tk, steps[s].tgt, 1'b0, 1'b0);
            bus.lookup_pc = 32'h100;
            #1;
            n_vec++;
            if (bus.predict_taken !== steps[s].et || bus.predict_pc !== steps[s].ep) begin
                n_err++;
                $display("FAIL train_step%0d: got taken=%b pc=%h, want taken=%b pc=%h", s,
                         bus.predict_taken, bus.predict_pc, steps[s].et, steps[s].ep);
            end
        end
    endtask

    task automatic test_alias();
        bus.lookup_pc = 32'h140;
        #1;
        n_vec++;
        if (bus.predict_taken !== 1'b0 || bus.predict_pc !== 32'h144) begin
            n_err++;
            $display("FAIL alias_miss: got taken=%b pc=%h, want taken=0 pc=00000144",
                     bus.predict_taken, bus.predict_pc);
        end
        do_update(32'h140, 1'b1, 32'h300, 1'b0, 1'b0);
        bus.lookup_pc = 32'h100;
        #1;
        n_vec++;
        if (bus.predict_taken !== 1'b0 || bus.predict_pc !== 32'h104) begin
            n_err++;
            $display("FAIL alias_evicted: got taken=%b pc=%h, want taken=0 pc=00000104",
                     bus.predict_taken, bus.predict_pc);
        end
        bus.lookup_pc = 32'h140;
        #1;
        n_vec++;
        if (bus.predict_taken !== 1'b1 || bus.predict_pc !== 32'h300) begin
            n_err++;
            $display("FAIL alias_new: got taken=%b pc=%h, want taken=1 pc=00000300",
                     bus.predict_taken, bus.predict_pc);
        end
    endtask

    task automatic test_stall();
        logic [31:0] pcs[3];
        pcs = '{32'h140, 32'h100, 32'h180};
        do_update(32'h140, 1'b0, 32'h0,   1'b1, 1'b1);
        do_update(32'h100, 1'b1, 32'h999, 1'b1, 1'b1);
        do_update(32'h180, 1'b1, 32'h777, 1'b0, 1'b1);
        foreach (pcs[k]) begin
            bus.lookup_pc = pcs[k];
            #1;
            n_vec++;
            if (bus.predict_taken !== f_taken(pcs[k]) || bus.predict_pc !== f_pc(pcs[k])) begin
                n_err++;
                $display("FAIL stall_frozen_%h: got taken=%b pc=%h, want taken=%b pc=%h",
                         pcs[k], bus.predict_taken, bus.predict_pc, f_taken(pcs[k]), f_pc(pcs[k]));
            end
        end
`ifdef BP_STATS_EN
        n_vec++;
        if (bus.stat_branches !== m_br[31:0] || bus.stat_mispredicts !== m_mp[31:0]) begin
            n_err++;
            $display("FAIL stall_stats: got br=%0d mp=%0d, want %0d %0d",
                     bus.stat_branches, bus.stat_mispredicts, m_br, m_mp);
        end
`endif
        @(negedge clk);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h140;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h444;
        bus.lookup_pc  = 32'h140;
        #1;
        n_vec++;
        if (bus.predict_taken !== 1'b1 || bus.predict_pc !== 32'h300) begin
            n_err++;
            $display("FAIL same_cycle_old: got taken=%b pc=%h, want taken=1 pc=00000300",
                     bus.predict_taken, bus.predict_pc);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        m_update(32'h140, 1'b1, 32'h444, 1'b0);
        #1;
        n_vec++;
        if (bus.predict_taken !== 1'b1 || bus.predict_pc !== 32'h444) begin
            n_err++;
            $display("FAIL same_cycle_new: got taken=%b pc=%h, want taken=1 pc=00000444",
                     bus.predict_taken, bus.predict_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] upc, lpc, tgt;
        bit          tk, mis, st;
        for (int n = 0; n < 400; n++) begin
            upc = rand_pc();
            lpc = ($urandom_range(0, 3) == 0) ? upc : rand_pc();
            tgt = $urandom();
            tk  = $urandom_range(0, 1);
            mis = $urandom_range(0, 1);
            st  = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            bus.upd_valid      = $urandom_range(0, 4) != 0;
            bus.upd_pc         = upc;
            bus.upd_taken      = tk;
            bus.upd_target     = tgt;
            bus.upd_mispredict = mis;
            bus.stall          = st;
            bus.lookup_pc      = lpc;
            #1;
            n_vec++;
            if (bus.predict_taken !== f_taken(lpc) || bus.predict_pc !== f_pc(lpc)) begin
                n_err++;
                $display("FAIL random_%0d lookup %h: got taken=%b pc=%h, want taken=%b pc=%h",
                         n, lpc, bus.predict_taken, bus.predict_pc, f_taken(lpc), f_pc(lpc));
            end
            @(posedge clk);
            #1;
            if (bus.upd_valid && !st) m_update(upc, tk, tgt, mis);
            idle_inputs();
        end
`ifdef BP_STATS_EN
        n_vec++;
        if (bus.stat_branches !== m_br[31:0] || bus.stat_mispredicts !== m_mp[31:0]) begin
            n_err++;
            $display("FAIL random_stats: got br=%0d mp=%0d, want %0d %0d",
                     bus.stat_branches, bus.stat_mispredicts, m_br, m_mp);
        end
`endif
    endtask

    task automatic test_stats();
`ifdef BP_STATS_EN
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            do_update(rand_pc(), 1'($urandom_range(0, 1)), $urandom(), (i % 3) == 1, 1'b0);
        end
        n_vec++;
        if (bus.stat_branches !== 32'd10 || bus.stat_mispredicts !== 32'd3) begin
            n_err++;
            $display("FAIL stats_count: got br=%0d mp=%0d, want 10 3",
                     bus.stat_branches, bus.stat_mispredicts);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_update(32'h100, 1'b1, 32'h520, 1'b1, 1'b0);
        @(negedge clk);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = 32'h100;
        bus.upd_taken      = 1'b1;
        bus.upd_target     = 32'h640;
        bus.upd_mispredict = 1'b1;
        bus.lookup_pc      = 32'h100;
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        n_vec++;
        if (bus.predict_taken !== 1'b0 || bus.predict_pc !== 32'h104) begin
            n_err++;
            $display("FAIL reset_mid_lookup: got taken=%b pc=%h, want taken=0 pc=00000104",
                     bus.predict_taken, bus.predict_pc);
        end
`ifdef BP_STATS_EN
        n_vec++;
        if (bus.stat_branches !== 32'd0 || bus.stat_mispredicts !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_stats: got br=%0d mp=%0d, want 0 0",
                     bus.stat_branches, bus.stat_mispredicts);
        end
`endif
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.predict_taken !== 1'b0 || bus.predict_pc !== 32'h104) begin
            n_err++;
            $display("FAIL reset_mid_after: got taken=%b pc=%h, want taken=0 pc=00000104",
                     bus.predict_taken, bus.predict_pc);
        end
    endtask

    initial begin
        bus.lookup_pc = '0;
        idle_inputs();
        test_reset();
        test_train();
        test_alias();
        test_stall();
        test_random();
        test_stats();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
